uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO that sits directly upstream of `uart_top`'s TX data interface. It decouples a bursty host byte producer from the UART transmitter. Host bytes are accepted on a valid/ready handshake and stored in order. They are then presented to the UART's `i_data`/`i_data_valid` and popped on its `o_ready`. Occupancy, almost-full and sticky overflow status are exported for flow control and debug.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `AFULL_THRESH`, 12: `o_afull` asserts when occupancy ≥ this value; range 1..DEPTH.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_flush`  in  1  synchronous clear of all stored bytes.
- `i_wdata`  in  8  host byte.
- `i_wvalid`  in  1  host byte valid.
- `o_wready`  out  1  FIFO can accept a byte.
- `o_tx_data`  out  8  head byte, drives UART `i_data`.
- `o_tx_valid`  out  1  head byte valid, drives UART `i_data_valid`.
- `i_tx_ready`  in  1  UART `o_ready`; pops head when high with `o_tx_valid`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_empty`  out  1  count == 0.
- `o_full`  out  1  count == DEPTH.
- `o_afull`  out  1  count ≥ AFULL_THRESH.
- `o_overflow`  out  1  sticky overflow flag.
- `i_clr_ovf`  in  1  clears `o_overflow`.

## Operation
- **Storage:** DEPTH×8 register array, read pointer, write pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 with no special handling.
- **Push:** occurs at a rising edge when `i_wvalid & o_wready`. `i_wdata` is written at the write pointer, then the write pointer increments.
- **Pop:** occurs at a rising edge when `o_tx_valid & i_tx_ready`. The read pointer increments.
- **Ready/valid outputs:**
  - `o_wready = !o_full & !i_flush`. It has no dependence on `i_tx_ready`, so a full FIFO refuses a write even when a pop happens in the same cycle.
  - `o_tx_valid = !o_empty & !i_flush`.
- **Head data:** `o_tx_data` is the array entry at the read pointer, first-word-fall-through. It holds stable while `o_tx_valid & !i_tx_ready`.
- **Count update:**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- **Flush:** when `i_flush` is high at an edge, both pointers and the count go to 0. Flush has priority over push and pop in that cycle, and any concurrent write is discarded. `o_overflow` is not affected.
- **Overflow:**
  - Set at an edge when `i_wvalid & o_full & !i_flush`. The byte is dropped and stored contents are unchanged.
  - Cleared at an edge when `i_clr_ovf` is high.
  - If set and clear occur in the same cycle, set wins.
- **Reset values:**
  - `o_wready`=1, `o_tx_valid`=0, `o_tx_data`=8'h00 (array cleared on reset).
  - `o_count`=0, `o_empty`=1, `o_full`=0, `o_afull`=0, `o_overflow`=0.
- **Reset mid-operation:** all contents are lost. Outputs take their reset values immediately (asynchronously), without waiting for a clock edge.

## Timing
- All state changes on the `clk` rising edge only; `rst` is the sole asynchronous input.
- **Write-to-valid latency:** a byte pushed into an empty FIFO at edge N gives `o_tx_valid`=1 and `o_tx_data`=byte in the cycle after edge N.
- **Pop-to-next-head:** the next head byte appears in the cycle after the popping edge.
- **Status outputs:** `o_count`, `o_empty`, `o_full`, `o_afull` and `o_overflow` derive from registered state only.
- **Combinational input-to-output paths:** only `i_flush` reaches `o_wready` and `o_tx_valid` combinationally. `i_wdata`, `i_wvalid` and `i_tx_ready` have no combinational path to any output.
- **Throughput:** sustained 1 push + 1 pop per cycle when neither full nor empty.

## Test plan
1. **Reset state:** assert `rst` asynchronously mid-cycle → all outputs at reset values before the next edge: `o_wready`=1, `o_empty`=1, `o_count`=0.
2. **Single byte, fall-through:** push 8'hA5 with `i_tx_ready`=0 → next cycle `o_tx_valid`=1, `o_tx_data`=8'hA5, `o_count`=1. Hold for 3 cycles: data stable. Then pulse `i_tx_ready` for one cycle → `o_empty`=1 on the following cycle.
3. **Fill, almost-full, overflow:** DEPTH=16, `i_tx_ready`=0, push 8'h00..8'h0F.
   - `o_afull` rises after the 12th push.
   - `o_full`=1 and `o_wready`=0 after the 16th push.
   - Drive `i_wvalid` with 8'hFF → `o_overflow`=1 and `o_count` stays 16.
   - Drain → bytes out exactly 8'h00..8'h0F, no 8'hFF.
   - Pulse `i_clr_ovf` → `o_overflow`=0.
4. **Streaming and wrap:** prefill 3 bytes, then push and pop every cycle for 40 bytes (incrementing values) → `o_count` constant at 3 and output order matches input order across multiple pointer wraps.
5. **Flush collision:** with count=5 and `o_overflow`=1, assert `i_flush` while `i_wvalid`=1 and `i_tx_ready`=1.
   - That cycle: `o_wready`=0 and `o_tx_valid`=0.
   - Next cycle: `o_count`=0 and `o_empty`=1, the written byte never appears, and `o_overflow` is still 1.
6. **Reset mid-stream:** assert `rst` during the streaming of test 4, then release and push 8'h3C → first popped byte is 8'h3C and `o_count` returns to 0 after the pop.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: valid/ready host side, first-word-fall-through
// head toward the UART, plus occupancy, almost-full and sticky overflow status.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic [7:0]                 i_wdata,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_afull,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             overflow;
    logic             push;
    logic             pop;
    logic             ovf_set;

    // Status comes from registered state only; i_flush is the one input that
    // gates the handshake outputs combinationally.
    assign o_count    = count;
    assign o_empty    = (count == '0);
    assign o_full     = (count == CNT_W'(DEPTH));
    assign o_afull    = (count >= CNT_W'(AFULL_THRESH));
    assign o_overflow = overflow;
    assign o_wready   = !o_full && !i_flush;
    assign o_tx_valid = !o_empty && !i_flush;
    assign o_tx_data  = mem[rd_ptr];

    assign push    = i_wvalid && o_wready;
    assign pop     = o_tx_valid && i_tx_ready;
    assign ovf_set = i_wvalid && o_full && !i_flush;

    always_comb begin
        // NOTE: default assigned first so every path drives count_next; no latch.
        count_next = count;
        if (i_flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_next;
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Set wins over a simultaneous clear.
            if (ovf_set)
                overflow <= 1'b1;
            else if (i_clr_ovf)
                overflow <= 1'b0;
        end
    end

    // NOTE: the array is reset because the head byte must read 8'h00 out of
    // reset; this costs a flop array rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a queue scoreboard and a small occupancy/overflow model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_flush;
    logic [7:0] i_wdata;
    logic       i_wvalid;
    logic       o_wready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_afull;
    logic       o_overflow;
    logic       i_clr_ovf;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] sb[$];
    int         m_count;
    bit         m_ovf;
    int         v;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_wdata    (i_wdata),
        .i_wvalid   (i_wvalid),
        .o_wready   (o_wready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_count    (o_count),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_afull    (o_afull),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wready"},   o_wready,   1);
        check({tag, "_tx_valid"}, o_tx_valid, 0);
        check({tag, "_tx_data"},  o_tx_data,  0);
        check({tag, "_count"},    o_count,    0);
        check({tag, "_empty"},    o_empty,    1);
        check({tag, "_full"},     o_full,     0);
        check({tag, "_afull"},    o_afull,    0);
        check({tag, "_overflow"}, o_overflow, 0);
    endtask

    // One clock: settle inputs, predict the edge from the model, pop-compare
    // against the scoreboard, advance to just after the edge, check status.
    task automatic tick();
        logic [7:0] exp;
        bit push_m, pop_m;
        #1;
        pop_m  = i_tx_ready && (m_count > 0) && !i_flush;
        push_m = i_wvalid && (m_count < DEPTH) && !i_flush;
        if (pop_m) begin
            check("pop_valid", o_tx_valid, 1);
            exp = sb.pop_front();
            check("pop_data", o_tx_data, exp);
        end
        if (i_wvalid && (m_count == DEPTH) && !i_flush)
            m_ovf = 1'b1;
        else if (i_clr_ovf)
            m_ovf = 1'b0;
        if (push_m) sb.push_back(i_wdata);
        if (i_flush) begin
            sb.delete();
            m_count = 0;
        end else begin
            m_count = m_count + int'(push_m) - int'(pop_m);
        end
        @(posedge clk);
        #1;
        check("count", o_count, m_count);
        check("overflow", o_overflow, m_ovf);
    endtask

    initial begin
        rst        = 1'b1;
        i_flush    = 1'b0;
        i_wdata    = 8'h00;
        i_wvalid   = 1'b0;
        i_tx_ready = 1'b0;
        i_clr_ovf  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single byte fall-through, hold while not ready, then pop.
        i_wdata  = 8'hA5;
        i_wvalid = 1'b1;
        tick();
        i_wvalid = 1'b0;
        check("fwft_valid", o_tx_valid, 1);
        check("fwft_data",  o_tx_data,  8'hA5);
        repeat (3) begin
            tick();
            check("hold_data", o_tx_data, 8'hA5);
        end
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        check("single_empty", o_empty, 1);

        // Fill, almost-full edge, overflow, drain.
        for (int i = 0; i < DEPTH; i++) begin
            i_wdata  = 8'(i);
            i_wvalid = 1'b1;
            tick();
            if (i == 10) check("afull_at_11", o_afull, 0);
            if (i == 11) check("afull_at_12", o_afull, 1);
        end
        check("full",        o_full,   1);
        check("full_wready", o_wready, 0);
        i_wdata = 8'hFF;
        tick();
        i_wvalid = 1'b0;
        check("ovf_set",   o_overflow, 1);
        check("ovf_count", o_count,    16);
        i_tx_ready = 1'b1;
        repeat (DEPTH) tick();
        i_tx_ready = 1'b0;
        check("drain_empty", o_empty, 1);
        check("drain_sb",    sb.size(), 0);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check("ovf_clear", o_overflow, 0);

        // Streaming across several pointer wraps with a constant occupancy of 3.
        v = 8'h40;
        i_wvalid = 1'b1;
        repeat (3) begin
            i_wdata = 8'(v);
            v++;
            tick();
        end
        i_tx_ready = 1'b1;
        repeat (40) begin
            i_wdata = 8'(v);
            v++;
            tick();
            check("stream_count", o_count, 3);
        end
        i_wvalid = 1'b0;
        repeat (3) tick();
        i_tx_ready = 1'b0;
        check("stream_empty", o_empty, 1);

        // Flush colliding with a write and a pop while overflow is set.
        i_wvalid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            i_wdata = 8'(8'h80 + i);
            tick();
        end
        i_wvalid   = 1'b0;
        i_tx_ready = 1'b1;
        repeat (11) tick();
        check("pre_flush_count", o_count,    5);
        check("pre_flush_ovf",   o_overflow, 1);
        i_flush  = 1'b1;
        i_wvalid = 1'b1;
        i_wdata  = 8'hEE;
        #1;
        check("flush_wready",   o_wready,   0);
        check("flush_tx_valid", o_tx_valid, 0);
        tick();
        i_flush    = 1'b0;
        i_wvalid   = 1'b0;
        i_tx_ready = 1'b0;
        check("flush_count", o_count,    0);
        check("flush_empty", o_empty,    1);
        check("flush_ovf",   o_overflow, 1);
        i_wdata  = 8'h77;
        i_wvalid = 1'b1;
        tick();
        i_wvalid   = 1'b0;
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        i_clr_ovf  = 1'b1;
        tick();
        i_clr_ovf = 1'b0;

        // Asynchronous reset in the middle of streaming.
        i_wvalid = 1'b1;
        repeat (2) begin
            i_wdata = 8'(v);
            v++;
            tick();
        end
        i_tx_ready = 1'b1;
        repeat (10) begin
            i_wdata = 8'(v);
            v++;
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        i_wvalid   = 1'b0;
        i_tx_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_wdata  = 8'h3C;
        i_wvalid = 1'b1;
        tick();
        i_wvalid = 1'b0;
        check("post_rst_head", o_tx_data, 8'h3C);
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        check("post_rst_count", o_count, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
